// File: rtl/tmds_deserializer_1_to_10.sv
// TMDS 1:10 receive deserializer: shifts one channel LSB-first and
// locks the 10-bit word boundary on HDMI control tokens.
//
// Ports:
//   i_tmdsclk  bit clock, all logic on its rising edge
//   i_reset_n  asynchronous active-low reset
//   i_serial   serial TMDS bit, synchronous to i_tmdsclk
//   o_data     aligned character, bit 0 received first
//   o_valid    one-cycle strobe marking new o_data/o_is_ctrl/o_ctrl
//   o_locked   high while word alignment is locked
//   o_is_ctrl  o_data is one of the four control tokens
//   o_ctrl     {c1,c0} of the token, 00 when o_is_ctrl is low
module tmds_deserializer_1_to_10 #(
   parameter int LOCK_COUNT   = 8,
   parameter int UNLOCK_COUNT = 4
) (
   input  logic       i_tmdsclk,
   input  logic       i_reset_n,
   input  logic       i_serial,
   output logic [9:0] o_data,
   output logic       o_valid,
   output logic       o_locked,
   output logic       o_is_ctrl,
   output logic [1:0] o_ctrl
);

   localparam int LW = $clog2(LOCK_COUNT + 1);
   localparam int MW = $clog2(UNLOCK_COUNT + 1);

   localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_COUNT);
   localparam logic [LW-1:0] LOCK_ONE = LW'(1);
   localparam logic [MW-1:0] MISS_MAX = MW'(UNLOCK_COUNT);
   localparam logic [MW-1:0] MISS_ONE = MW'(1);

   localparam logic [9:0] TOK_00 = 10'b1101010100;
   localparam logic [9:0] TOK_01 = 10'b0010101011;
   localparam logic [9:0] TOK_10 = 10'b0101010100;
   localparam logic [9:0] TOK_11 = 10'b1010101011;

   typedef enum logic {
      SEARCH,
      LOCKED
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [9:0]    sr;
   logic [3:0]    bit_cnt;
   logic [3:0]    cnt_nxt;
   logic [LW-1:0] lock_cnt;
   logic [LW-1:0] lock_nxt;
   logic [MW-1:0] miss_cnt;
   logic [MW-1:0] miss_nxt;
   logic          match;
   logic [1:0]    ctrl;
   logic          boundary;
   logic          load;

   // Tokens are mutually exclusive, so at most one arm can hit.
   always_comb begin
      match = 1'b1;
      ctrl  = 2'b00;
      unique case (1'b1)
         (sr == TOK_00): ctrl = 2'b00;
         (sr == TOK_01): ctrl = 2'b01;
         (sr == TOK_10): ctrl = 2'b10;
         (sr == TOK_11): ctrl = 2'b11;
         default:        match = 1'b0;
      endcase
   end

   assign boundary = (bit_cnt == 4'd9);

   always_comb begin
      state_nxt = state;
      lock_nxt  = lock_cnt;
      miss_nxt  = miss_cnt;
      cnt_nxt   = boundary ? 4'd0 : bit_cnt + 4'd1;
      load      = 1'b0;
      unique case (state)
         SEARCH: begin
            if (match && !boundary) begin
               // Token seen off-phase: restart the phase on it.
               cnt_nxt  = 4'd0;
               lock_nxt = LOCK_ONE;
            end else if (match) begin
               if (lock_cnt != LOCK_MAX)
                  lock_nxt = lock_cnt + LOCK_ONE;
               if (lock_cnt >= LOCK_MAX - LOCK_ONE) begin
                  state_nxt = LOCKED;
                  miss_nxt  = '0;
               end
            end else if (boundary) begin
               lock_nxt = '0;
            end
         end
         LOCKED: begin
            load = boundary;
            if (match && boundary) begin
               miss_nxt = '0;
            end else if (match) begin
               if (miss_cnt != MISS_MAX)
                  miss_nxt = miss_cnt + MISS_ONE;
               // Lost alignment: fall back and realign on this token.
               if (miss_cnt >= MISS_MAX - MISS_ONE) begin
                  state_nxt = SEARCH;
                  cnt_nxt   = 4'd0;
                  lock_nxt  = LOCK_ONE;
               end
            end
         end
         default: state_nxt = SEARCH;
      endcase
   end

   always_ff @(posedge i_tmdsclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sr        <= '0;
         bit_cnt   <= '0;
         state     <= SEARCH;
         lock_cnt  <= '0;
         miss_cnt  <= '0;
         o_data    <= '0;
         o_valid   <= 1'b0;
         o_locked  <= 1'b0;
         o_is_ctrl <= 1'b0;
         o_ctrl    <= 2'b00;
      end else begin
         sr       <= {i_serial, sr[9:1]};
         bit_cnt  <= cnt_nxt;
         state    <= state_nxt;
         lock_cnt <= lock_nxt;
         miss_cnt <= miss_nxt;
         o_valid  <= load;
         o_locked <= (state_nxt == LOCKED);
         if (load) begin
            o_data    <= sr;
            o_is_ctrl <= match;
            o_ctrl    <= ctrl;
         end
      end
   end

endmodule

// File: tb/tb_tmds_deserializer_1_to_10.sv
// Self-checking bench for tmds_deserializer_1_to_10: serial stimulus
// with a queue of expected characters checked on each o_valid.
module tb_tmds_deserializer_1_to_10;

   localparam logic [9:0] T00 = 10'b1101010100;
   localparam logic [9:0] T01 = 10'b0010101011;
   localparam logic [9:0] T10 = 10'b0101010100;
   localparam logic [9:0] T11 = 10'b1010101011;
   localparam logic [9:0] D1  = 10'b0000011111;
   localparam logic [9:0] D2  = 10'b0101010101;
   localparam logic [9:0] D3  = 10'b1110001100;
   // T10 seen one bit late: {T10[8:0], extra 0}
   localparam logic [9:0] MIS = 10'b1010101000;

   typedef struct packed {
      logic [9:0] data;
      logic       is_ctrl;
      logic [1:0] ctrl;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       ser;
   logic       ser_g;
   logic       ser_r;
   logic [9:0] o_data;
   logic       o_valid;
   logic       o_locked;
   logic       o_is_ctrl;
   logic [1:0] o_ctrl;
   logic [9:0] d_g;
   logic       v_g;
   logic       lk_g;
   logic       c_g;
   logic [1:0] k_g;
   logic [9:0] d_r;
   logic       v_r;
   logic       lk_r;
   logic       c_r;
   logic [1:0] k_r;

   exp_t sb[$];
   int   n_vec;
   int   n_err;
   int   cyc;
   int   last_v;

   tmds_deserializer_1_to_10 dut (
      .i_tmdsclk (clk),
      .i_reset_n (rst_n),
      .i_serial  (ser),
      .o_data    (o_data),
      .o_valid   (o_valid),
      .o_locked  (o_locked),
      .o_is_ctrl (o_is_ctrl),
      .o_ctrl    (o_ctrl)
   );

   tmds_deserializer_1_to_10 dut_g (
      .i_tmdsclk (clk),
      .i_reset_n (rst_n),
      .i_serial  (ser_g),
      .o_data    (d_g),
      .o_valid   (v_g),
      .o_locked  (lk_g),
      .o_is_ctrl (c_g),
      .o_ctrl    (k_g)
   );

   tmds_deserializer_1_to_10 dut_r (
      .i_tmdsclk (clk),
      .i_reset_n (rst_n),
      .i_serial  (ser_r),
      .o_data    (d_r),
      .o_valid   (v_r),
      .o_locked  (lk_r),
      .o_is_ctrl (c_r),
      .o_ctrl    (k_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic exp_t mk(input logic [9:0] d,
                               input logic c,
                               input logic [1:0] k);
      exp_t e;
      e.data    = d;
      e.is_ctrl = c;
      e.ctrl    = k;
      return e;
   endfunction

   // One bit time; any o_valid is matched against the scoreboard.
   task automatic send_bit(input logic b);
      exp_t e;
      ser = b;
      @(posedge clk);
      #1;
      cyc++;
      if (o_valid === 1'b1) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL sb_extra: got %b/%b/%b, none expected",
                     o_data, o_is_ctrl, o_ctrl);
         end else begin
            e = sb.pop_front();
            if ({o_data, o_is_ctrl, o_ctrl} !== e) begin
               n_err++;
               $display("FAIL sb_word: got %b/%b/%b want %b/%b/%b",
                        o_data, o_is_ctrl, o_ctrl,
                        e.data, e.is_ctrl, e.ctrl);
            end
         end
         n_vec++;
         if (cyc - last_v < 10) begin
            n_err++;
            $display("FAIL valid_gap: got %0d cycles want >=10",
                     cyc - last_v);
         end
         last_v = cyc;
      end
   endtask

   task automatic send_word(input logic [9:0] w, input int from);
      for (int k = from; k < 10; k++) send_bit(w[k]);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) send_bit(1'b0);
      sb.delete();
      last_v = -100;
      rst_n = 1'b1;
   endtask

   task automatic drain(input string tag);
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL %s_drain: %0d words left want 0",
                  tag, sb.size());
      end
   endtask

   // Optional junk 101, eight tokens, then first bit of nxt.
   task automatic lock_on(input logic [9:0] tok, input logic junk,
                          input string tag, input logic [9:0] nxt);
      if (junk) begin
         send_bit(1'b1);
         send_bit(1'b0);
         send_bit(1'b1);
      end
      for (int n = 1; n <= 8; n++) begin
         send_word(tok, 0);
         n_vec++;
         if (o_locked !== 1'b0) begin
            n_err++;
            $display("FAIL %s_early: token %0d o_locked=%b want 0",
                     tag, n, o_locked);
         end
      end
      send_bit(nxt[0]);
      n_vec++;
      if (o_locked !== 1'b1) begin
         n_err++;
         $display("FAIL %s_rise: o_locked=%b want 1", tag, o_locked);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int n = 0; n < 20; n++) begin
         send_bit($urandom_range(0, 1) == 1);
         n_vec++;
         if ({o_data, o_valid, o_locked, o_is_ctrl, o_ctrl} !== 15'd0)
         begin
            n_err++;
            $display("FAIL rst_hold: outputs=%b want 0",
                     {o_data, o_valid, o_locked, o_is_ctrl, o_ctrl});
         end
      end
      last_v = -100;
      rst_n = 1'b1;
      sb.push_back(mk(T00, 1'b1, 2'b00));
      lock_on(T00, 1'b0, "rst_lock", T00);
      send_word(T00, 1);
      sb.push_back(mk(T00, 1'b1, 2'b00));
      send_word(T00, 0);
      send_bit(1'b0);
      n_vec++;
      if ({o_valid, o_locked} !== 2'b11) begin
         n_err++;
         $display("FAIL rst_pre: valid/locked=%b want 11",
                  {o_valid, o_locked});
      end
      #1;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({o_valid, o_locked, o_data} !== 12'd0) begin
         n_err++;
         $display("FAIL rst_async: valid/locked/data=%b want 0",
                  {o_valid, o_locked, o_data});
      end
      send_bit(1'b1);
      send_bit(1'b0);
      sb.delete();
      last_v = -100;
      rst_n = 1'b1;
      sb.push_back(mk(T01, 1'b1, 2'b01));
      lock_on(T01, 1'b0, "rst_relock", T01);
      send_word(T01, 1);
      send_bit(1'b1);
      drain("rst");
   endtask

   task automatic test_lock_acq();
      do_reset();
      sb.push_back(mk(T00, 1'b1, 2'b00));
      lock_on(T00, 1'b1, "lock", T00);
      send_word(T00, 1);
      sb.push_back(mk(T00, 1'b1, 2'b00));
      send_word(T00, 0);
      send_bit(1'b1);
      drain("lock");
   endtask

   task automatic test_data();
      do_reset();
      sb.push_back(mk(D1, 1'b0, 2'b00));
      lock_on(T00, 1'b1, "data_lock", D1);
      send_word(D1, 1);
      sb.push_back(mk(D2, 1'b0, 2'b00));
      send_word(D2, 0);
      sb.push_back(mk(D3, 1'b0, 2'b00));
      send_word(D3, 0);
      sb.push_back(mk(T11, 1'b1, 2'b11));
      send_word(T11, 0);
      send_bit(1'b0);
      drain("data");
   endtask

   task automatic test_interrupted();
      do_reset();
      for (int n = 1; n <= 6; n++) begin
         send_word((n == 6) ? D2 : T01, 0);
         n_vec++;
         if (o_locked !== 1'b0) begin
            n_err++;
            $display("FAIL intr_pre: word %0d o_locked=%b want 0",
                     n, o_locked);
         end
      end
      lock_on(T01, 1'b0, "intr", T01);
      drain("intr");
   endtask

   task automatic test_bit_slip();
      do_reset();
      sb.push_back(mk(T10, 1'b1, 2'b10));
      lock_on(T10, 1'b1, "slip_lock", T10);
      send_word(T10, 1);
      sb.push_back(mk(T10, 1'b1, 2'b10));
      send_word(T10, 0);
      send_bit(1'b0);
      repeat (4) sb.push_back(mk(MIS, 1'b0, 2'b00));
      for (int n = 1; n <= 4; n++) begin
         send_word(T10, 0);
         n_vec++;
         if (o_locked !== 1'b1) begin
            n_err++;
            $display("FAIL slip_hold: token %0d o_locked=%b want 1",
                     n, o_locked);
         end
      end
      send_bit(1'b0);
      n_vec++;
      if (o_locked !== 1'b0) begin
         n_err++;
         $display("FAIL slip_fall: o_locked=%b want 0", o_locked);
      end
      send_word(T10, 1);
      for (int n = 1; n <= 6; n++) begin
         send_word(T10, 0);
         n_vec++;
         if (o_locked !== 1'b0) begin
            n_err++;
            $display("FAIL slip_early: token %0d o_locked=%b want 0",
                     n, o_locked);
         end
      end
      send_bit(1'b0);
      n_vec++;
      if (o_locked !== 1'b1) begin
         n_err++;
         $display("FAIL slip_relock: o_locked=%b want 1", o_locked);
      end
      drain("slip");
   endtask

   task automatic test_three_ch();
      logic [9:0] wb;
      logic [9:0] wg;
      logic [9:0] wr;
      do_reset();
      wb = T01;
      wg = T00;
      wr = T00;
      for (int n = 0; n < 8; n++) begin
         for (int k = 0; k < 10; k++) begin
            ser_g = wg[k];
            ser_r = wr[k];
            send_bit(wb[k]);
         end
      end
      wb = D1;
      wg = D2;
      wr = D3;
      for (int rep = 0; rep < 4; rep++) begin
         if (rep < 3) sb.push_back(mk(D1, 1'b0, 2'b00));
         ser_g = wg[0];
         ser_r = wr[0];
         send_bit(wb[0]);
         n_vec++;
         if (rep == 0) begin
            if ({o_locked, lk_g, lk_r} !== 3'b111) begin
               n_err++;
               $display("FAIL ch3_lock: locked b/g/r=%b want 111",
                        {o_locked, lk_g, lk_r});
            end
         end else begin
            if ({v_g, d_g} !== {1'b1, wg}) begin
               n_err++;
               $display("FAIL ch3_green: valid/data=%b want %b",
                        {v_g, d_g}, {1'b1, wg});
            end
            n_vec++;
            if ({v_r, d_r} !== {1'b1, wr}) begin
               n_err++;
               $display("FAIL ch3_red: valid/data=%b want %b",
                        {v_r, d_r}, {1'b1, wr});
            end
         end
         if (rep < 3) begin
            for (int k = 1; k < 10; k++) begin
               ser_g = wg[k];
               ser_r = wr[k];
               send_bit(wb[k]);
            end
         end
      end
      ser_g = 1'b0;
      ser_r = 1'b0;
      drain("ch3");
   endtask

   initial begin
      rst_n  = 1'b0;
      ser    = 1'b0;
      ser_g  = 1'b0;
      ser_r  = 1'b0;
      n_vec  = 0;
      n_err  = 0;
      cyc    = 0;
      last_v = -100;
      test_reset();
      test_lock_acq();
      test_data();
      test_interrupted();
      test_bit_slip();
      test_three_ch();
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
